alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin arbiter sharing one combinational ALU between two requesters.
//   A request is accepted in IDLE, its operands are registered, the shared ALU
//   is evaluated for one cycle in EXEC, and the captured result is returned to
//   the winner on its response channel in RESP.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_reqN_valid / o_reqN_ready   request handshake, N = 0,1
//   i_reqN_a, i_reqN_b, i_reqN_op operands and ALU op for requester N
//   o_rspN_valid / i_rspN_ready   response handshake, N = 0,1
//   o_rsp_z, o_rsp_zero, o_rsp_err  shared response payload
//   o_alu_a, o_alu_b, o_alu_op    drive the shared ALU (always the captured regs)
//   i_alu_z, i_alu_zero           combinational ALU result
//   o_busy                        state is not IDLE
//
// state  | meaning
// IDLE   | waiting for a request; grants one combinationally
// EXEC   | shared ALU driven from captured operands; result captured at edge
// RESP   | result presented to the winner until it takes it
module alu_share_arbiter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [W-1:0] i_req0_a,
  input  logic [W-1:0] i_req0_b,
  input  logic [2:0]   i_req0_op,
  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [W-1:0] i_req1_a,
  input  logic [W-1:0] i_req1_b,
  input  logic [2:0]   i_req1_op,
  output logic         o_rsp0_valid,
  input  logic         i_rsp0_ready,
  output logic         o_rsp1_valid,
  input  logic         i_rsp1_ready,
  output logic [W-1:0] o_rsp_z,
  output logic         o_rsp_zero,
  output logic         o_rsp_err,
  output logic [W-1:0] o_alu_a,
  output logic [W-1:0] o_alu_b,
  output logic [2:0]   o_alu_op,
  input  logic [W-1:0] i_alu_z,
  input  logic         i_alu_zero,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last_grant;
  logic         r_cur;
  logic [W-1:0] r_op_a;
  logic [W-1:0] r_op_b;
  logic [2:0]   r_op_code;
  logic [W-1:0] r_res_z;
  logic         r_res_zero;
  logic         r_res_err;

  logic w_grant0;
  logic w_grant1;
  logic w_op_legal;
  logic w_rsp_take;

  // Grant is suppressed during reset so a request seen in a reset cycle is
  // never handshaken. On a tie the requester that did not win last goes.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == S_IDLE && !i_rst) begin
      if (i_req0_valid && i_req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = i_req0_valid;
        w_grant1 = i_req1_valid;
      end
    end
  end

  always_comb begin
    case (r_op_code)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: w_op_legal = 1'b1;
      default:                                w_op_legal = 1'b0;
    endcase
  end

  assign w_rsp_take = r_cur ? i_rsp1_ready : i_rsp0_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant0 || w_grant1) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_take) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_req0_ready = w_grant0;
    o_req1_ready = w_grant1;
    o_rsp0_valid = (r_state == S_RESP) && !r_cur;
    o_rsp1_valid = (r_state == S_RESP) &&  r_cur;
    o_busy       = (r_state != S_IDLE);
  end

  assign o_alu_a    = r_op_a;
  assign o_alu_b    = r_op_b;
  assign o_alu_op   = r_op_code;
  assign o_rsp_z    = r_res_z;
  assign o_rsp_zero = r_res_zero;
  assign o_rsp_err  = r_res_err;

  // Operand capture and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
      r_cur        <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_code    <= 3'b000;
      r_res_z      <= '0;
      r_res_zero   <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_op_a    <= w_grant1 ? i_req1_a  : i_req0_a;
        r_op_b    <= w_grant1 ? i_req1_b  : i_req0_b;
        r_op_code <= w_grant1 ? i_req1_op : i_req0_op;
        r_cur     <= w_grant1;
      end
      if (r_state == S_EXEC) begin
        // Illegal ops ignore whatever the ALU produced.
        if (w_op_legal) begin
          r_res_z    <= i_alu_z;
          r_res_zero <= i_alu_zero;
          r_res_err  <= 1'b0;
        end else begin
          r_res_z    <= '0;
          r_res_zero <= 1'b1;
          r_res_err  <= 1'b1;
        end
        r_last_grant <= r_cur;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. A behavioural ALU answers the
//   shared ALU port; a monitor pushes the expected result of every accepted
//   request into a scoreboard, and each scenario task pops and compares when a
//   response appears.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_z;
  logic         rsp_zero, rsp_err;
  logic [W-1:0] alu_a, alu_b, alu_z;
  logic [2:0]   alu_op;
  logic         alu_zero;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int           who;
    logic [W-1:0] z;
    logic         zero;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   grant_cyc[$];

  alu_share_arbiter #(.W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_op(req0_op),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_op(req1_op),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
    .o_rsp_z(rsp_z), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_z(alu_z), .i_alu_zero(alu_zero), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU; returns garbage for illegal codes so the arbiter must override.
  always_comb begin
    alu_z = 32'hDEAD_BEEF;
    case (alu_op)
      3'b000: alu_z = alu_a & alu_b;
      3'b001: alu_z = alu_a | alu_b;
      3'b010: alu_z = alu_a + alu_b;
      3'b110: alu_z = alu_a - alu_b;
      3'b111: alu_z = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_z = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_z == '0);
  end

  function automatic exp_t model(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input int c);
    exp_t r;
    r.who  = who;
    r.cyc  = c;
    r.err  = 1'b0;
    r.z    = '0;
    case (op)
      3'b000: r.z = a & b;
      3'b001: r.z = a | b;
      3'b010: r.z = a + b;
      3'b110: r.z = a - b;
      3'b111: r.z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.zero = (r.z == '0);
    return r;
  endfunction

  // Accepted request at this negedge -> handshake at next edge -> response
  // visible two negedges later.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (req0_valid && req0_ready) begin
        sb.push_back(model(0, req0_a, req0_b, req0_op, cyc + 2));
        grants.push_back(0);
        grant_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1, req1_a, req1_b, req1_op, cyc + 2));
        grants.push_back(1);
        grant_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises valid and waits (bounded) for the grant; drops valid after the edge.
  task automatic drive(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, output bit ok);
    if (who == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else          begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((who == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h11; req0_b = 32'h22; req0_op = 3'b010;
    req1_a = 32'h33; req1_b = 32'h44; req1_op = 3'b001;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_a, alu_b, alu_op, rsp_z, rsp_zero, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b%b rspv=%b%b busy=%b alu=%h/%h/%b z=%h zero=%b err=%b, required all zero",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_a, alu_b, alu_op, rsp_z, rsp_zero, rsp_err);
    end
    tick();
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b rspv=%b%b, required 000", busy, rsp0_valid, rsp1_valid);
    end
    tick();
  endtask

  task automatic test_single_add();
    bit   ok;
    exp_t e;
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010; req0_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_grant: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({req0_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL add_exec: ready0=%b busy=%b, required 0 1", req0_ready, busy);
    end
    tick();
    req0_valid = 1'b0;
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL add_rsp: no response (valid0=%b valid1=%b queued=%0d), required one", rsp0_valid, rsp1_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err} !== {e.who == 1, e.who == 0, 32'd8, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL add_result: v1=%b v0=%b z=%h zero=%b err=%b, required v0 z=8 zero=0 err=0",
                 rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err);
      end
      n_tests++;
      if (cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL add_latency: response at cycle %0d, required %0d", cyc, e.cyc);
      end
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL add_complete: busy=%b valid0=%b, required 0 0", busy, rsp0_valid);
    end
    tick();
  endtask

  task automatic test_sub_slt();
    bit             ok;
    exp_t           e;
    logic [W-1:0]   a_tab [2] = '{32'd7, 32'hFFFF_FFFF};
    logic [W-1:0]   b_tab [2] = '{32'd7, 32'd1};
    logic [2:0]     op_tab[2] = '{3'b110, 3'b111};
    logic [W-1:0]   z_tab [2] = '{32'd0, 32'd1};
    logic           zr_tab[2] = '{1'b1, 1'b0};
    rsp1_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1, a_tab[k], b_tab[k], op_tab[k], ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL subslt_grant[%0d]: ready1 never rose, required a grant", k);
      end
      wait_rsp(ok);
      n_tests++;
      if (!ok || sb.size() == 0) begin
        n_fail++;
        $display("FAIL subslt_rsp[%0d]: no response, required one", k);
      end else begin
        e = sb.pop_front();
        n_tests++;
        if ({rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err} !== {2'b10, z_tab[k], zr_tab[k], 1'b0}) begin
          n_fail++;
          $display("FAIL subslt_result[%0d]: v1=%b v0=%b z=%h zero=%b err=%b, required v1 z=%h zero=%b err=0",
                   k, rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err, z_tab[k], zr_tab[k]);
        end
        n_tests++;
        if ({rsp_z, rsp_zero, rsp_err} !== {e.z, e.zero, e.err}) begin
          n_fail++;
          $display("FAIL subslt_model[%0d]: z=%h zero=%b err=%b, model z=%h zero=%b err=%b",
                   k, rsp_z, rsp_zero, rsp_err, e.z, e.zero, e.err);
        end
      end
      tick();
    end
  endtask

  task automatic run_tie(input string name, input int n_rsp);
    bit   ok;
    exp_t e;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    grants.delete(); grant_cyc.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < n_rsp; k++) begin
      wait_rsp(ok);
      n_tests++;
      if (!ok || sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s_rsp[%0d]: no response, required one", name, k);
      end else begin
        e = sb.pop_front();
        n_tests++;
        if ({rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err, cyc} !== {e.who == 1, e.who == 0, e.z, e.zero, e.err, e.cyc}) begin
          n_fail++;
          $display("FAIL %s_result[%0d]: v1=%b v0=%b z=%h zero=%b err=%b cyc=%0d, required who=%0d z=%h zero=%b err=%b cyc=%0d",
                   name, k, rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err, cyc, e.who, e.z, e.zero, e.err, e.cyc);
        end
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++;
    if (grants.size() != n_rsp) begin
      n_fail++;
      $display("FAIL %s_grant_count: %0d grants, required %0d", name, grants.size(), n_rsp);
    end else begin
      for (int k = 0; k < n_rsp; k++) begin
        n_tests++;
        if (grants[k] !== (k % 2)) begin
          n_fail++;
          $display("FAIL %s_grant_order[%0d]: granted %0d, required %0d", name, k, grants[k], k % 2);
        end
        if (k > 0) begin
          n_tests++;
          if (grant_cyc[k] - grant_cyc[k-1] !== 3) begin
            n_fail++;
            $display("FAIL %s_interval[%0d]: %0d cycles, required 3", name, k, grant_cyc[k] - grant_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    req0_a = 32'hF0; req0_b = 32'h0F; req0_op = 3'b001;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b000;
    run_tie("rr", 4);
    @(negedge clk);
    n_tests++;
    if ({busy, sb.size() == 0} !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_drain: busy=%b queued=%0d, required 0 and 0", busy, sb.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    drive(0, 32'd1, 32'd2, 3'b010, ok);
    req1_a = 32'd10; req1_b = 32'd20; req1_op = 3'b010; req1_valid = 1'b1;
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_rsp0: no response, required one");
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err} !== {2'b01, 32'd3, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_result: v1=%b v0=%b z=%h zero=%b err=%b, required v0 z=3", rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp0_valid, rsp1_valid, rsp_z, busy, req1_ready} !== {2'b10, 32'd3, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v0=%b v1=%b z=%h busy=%b ready1=%b, required 1 0 3 1 0",
                 k, rsp0_valid, rsp1_valid, rsp_z, busy, req1_ready);
      end
    end
    tick();
    rsp0_ready = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if ({req1_ready, rsp0_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_next_grant: ready1=%b v0=%b, required 1 0", req1_ready, rsp0_valid);
    end
    tick();
    req1_valid = 1'b0;
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_rsp1: no response, required one");
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err} !== {2'b10, 32'd30, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_result1: v1=%b v0=%b z=%h zero=%b err=%b, required v1 z=1e", rsp1_valid, rsp0_valid, rsp_z, rsp_zero, rsp_err);
      end
    end
    tick();
  endtask

  task automatic test_illegal();
    bit   ok;
    exp_t e;
    rsp0_ready = 1'b1;
    drive(0, 32'd9, 32'd4, 3'b011, ok);
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL illegal_rsp: no response, required one");
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp0_valid, rsp_z, rsp_zero, rsp_err, cyc} !== {1'b1, 32'd0, 1'b1, 1'b1, e.cyc}) begin
        n_fail++;
        $display("FAIL illegal_result: v0=%b z=%h zero=%b err=%b cyc=%0d, required 1 0 1 1 cyc=%0d",
                 rsp0_valid, rsp_z, rsp_zero, rsp_err, cyc, e.cyc);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    bit ok;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive(1, 32'd2, 32'd2, 3'b010, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_tests++;
    if ({busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_op, rsp_z, rsp_zero, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_values: busy=%b v=%b%b alu=%h/%h/%b z=%h zero=%b err=%b, required all zero",
               busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_op, rsp_z, rsp_zero, rsp_err);
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_dropped: response seen=%b for a dropped op, required 0", seen);
    end
    tick();
    req0_a = 32'd10;   req0_b = 32'd3;    req0_op = 3'b110;
    req1_a = 32'h12;   req1_b = 32'h30;   req1_op = 3'b001;
    run_tie("postrst", 2);
    tick();
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    test_reset();
    test_single_add();
    test_sub_slt();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
